pipeline_stall_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage CPU. It combines three stall/flush sources into per-stage write enables, flush and bubble controls:
- load-use hazard (from hazard detection)
- ID-stage taken branch
- multi-cycle data-memory handshake

It also keeps saturating stall/flush performance counters and traps a memory timeout.

---
 rtl/pipeline_stall_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline sequencer that merges load-use, branch-flush and data-memory stalls into
// per-stage enables. It also keeps saturating stall/flush counters and traps memory timeouts.
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_en_o,
  output logic             dmem_valid_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StInit, StRun, StMemWait, StError} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_en, dmem_valid, err;
  logic issue;  // evaluate the load-use / branch / normal rules this cycle

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_en     = 1'b0;
    dmem_valid  = 1'b0;
    err         = 1'b0;
    issue       = 1'b0;

    unique case (state_q)
      StInit: state_d = StRun;
      StRun: begin
        dmem_valid = dmem_req_i;
        if (dmem_req_i && !dmem_ack_i) begin
          state_d = StMemWait;
          wait_d  = WaitW'(1);
        end else begin
          issue = 1'b1;
        end
      end
      StMemWait: begin
        dmem_valid = 1'b1;
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (dmem_ack_i) begin
          issue   = 1'b1;
          state_d = StRun;
          wait_d  = '0;
        end else if (wait_q >= WaitW'(MEM_TIMEOUT)) begin
          state_d = StError;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StError: err = 1'b1;
      default: state_d = StInit;
    endcase

    if (issue) begin
      pipe_en = 1'b1;
      if (load_use_i) begin
        // Branch flush is suppressed: its operands are not valid until the load lands.
        idex_bubble = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = branch_taken_i;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == StRun || state_q == StMemWait) begin
      if (!pc_write && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (ifid_flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StInit;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_write_o    = pc_write;
  assign ifid_write_o  = ifid_write;
  assign ifid_flush_o  = ifid_flush;
  assign idex_bubble_o = idex_bubble;
  assign pipe_en_o     = pipe_en;
  assign dmem_valid_o  = dmem_valid;
  assign err_o         = err;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a default-sized instance and a small one
// (MEM_TIMEOUT=4, CNT_W=3) share stimulus and are checked against a reference model.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic lu = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;

  logic pc_a, ifw_a, fl_a, bub_a, pe_a, dv_a, err_a;
  logic [15:0] sc_a, fc_a;
  logic pc_b, ifw_b, fl_b, bub_b, pe_b, dv_b, err_b;
  logic [2:0] sc_b, fc_b;

  always #5 clk = ~clk;

  pipeline_stall_ctrl u_dut_a (
    .clk_i(clk), .rst_i(rst_i), .load_use_i(lu), .branch_taken_i(br),
    .dmem_req_i(req), .dmem_ack_i(ack), .pc_write_o(pc_a), .ifid_write_o(ifw_a),
    .ifid_flush_o(fl_a), .idex_bubble_o(bub_a), .pipe_en_o(pe_a), .dmem_valid_o(dv_a),
    .err_o(err_a), .stall_cnt_o(sc_a), .flush_cnt_o(fc_a)
  );

  pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst_i), .load_use_i(lu), .branch_taken_i(br),
    .dmem_req_i(req), .dmem_ack_i(ack), .pc_write_o(pc_b), .ifid_write_o(ifw_b),
    .ifid_flush_o(fl_b), .idex_bubble_o(bub_b), .pipe_en_o(pe_b), .dmem_valid_o(dv_b),
    .err_o(err_b), .stall_cnt_o(sc_b), .flush_cnt_o(fc_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } exp_t;
  exp_t sb[$];

  // Reference model state: 0 INIT, 1 RUN, 2 MEM_WAIT, 3 ERROR
  int m_st[2], m_w[2], m_sc[2], m_fc[2];
  int tmo[2]  = '{64, 4};
  int cmax[2] = '{65535, 7};

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_en, dmem_valid, err}
  function automatic logic [6:0] mdl_out(int st, logic l, logic b, logic q, logic a);
    logic go;
    logic [6:0] o;
    o  = '0;
    go = 1'b0;
    case (st)
      1: begin
        o[1] = q;
        if (!(q && !a)) go = 1'b1;
      end
      2: begin
        o[1] = 1'b1;
        go   = a;
      end
      3: o[0] = 1'b1;
      default: o = '0;
    endcase
    if (go) begin
      if (l) o[6:2] = 5'b00011;
      else   o[6:2] = {2'b11, b, 2'b01};
    end
    return o;
  endfunction

  function automatic logic [63:0] exp_vec(int i, logic l, logic b, logic q, logic a);
    logic [6:0] o;
    o = mdl_out(m_st[i], l, b, q, a);
    if (i == 0) return {25'b0, o, 16'(m_sc[0]), 16'(m_fc[0])};
    return {51'b0, o, 3'(m_sc[1]), 3'(m_fc[1])};
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_w[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  task automatic mdl_step(logic l, logic b, logic q, logic a);
    logic [6:0] o;
    for (int i = 0; i < 2; i++) begin
      o = mdl_out(m_st[i], l, b, q, a);
      if (m_st[i] == 1 || m_st[i] == 2) begin
        if (!o[6] && m_sc[i] < cmax[i]) m_sc[i]++;
        if (o[4] && m_fc[i] < cmax[i]) m_fc[i]++;
      end
      case (m_st[i])
        0: m_st[i] = 1;
        1: if (q && !a) begin m_st[i] = 2; m_w[i] = 1; end
        2: begin
          if (a) m_st[i] = 1;
          else if (m_w[i] >= tmo[i]) m_st[i] = 3;
          else m_w[i]++;
        end
        default: m_st[i] = 3;
      endcase
    end
  endtask

  task automatic compare_top();
    exp_t e;
    e = sb.pop_front();
    check_eq({e.tag, "/a"}, {25'b0, pc_a, ifw_a, fl_a, bub_a, pe_a, dv_a, err_a, sc_a, fc_a},
             e.exp_a);
    check_eq({e.tag, "/b"}, {51'b0, pc_b, ifw_b, fl_b, bub_b, pe_b, dv_b, err_b, sc_b, fc_b},
             e.exp_b);
  endtask

  task automatic cycle(input string tag, input logic r, input logic l, input logic b,
                       input logic q, input logic a);
    exp_t e;
    @(negedge clk);
    rst_i = r; lu = l; br = b; req = q; ack = a;
    if (!r) mdl_reset();
    e.tag   = tag;
    e.exp_a = exp_vec(0, l, b, q, a);
    e.exp_b = exp_vec(1, l, b, q, a);
    sb.push_back(e);
    #1;
    compare_top();
    if (r) mdl_step(l, b, q, a);
  endtask

  // Reset asserted between edges: outputs must fall back to INIT without a clock.
  task automatic async_reset(input string tag);
    exp_t e;
    @(negedge clk);
    #3;
    rst_i = 1'b0;
    mdl_reset();
    e.tag   = tag;
    e.exp_a = exp_vec(0, lu, br, req, ack);
    e.exp_b = exp_vec(1, lu, br, req, ack);
    sb.push_back(e);
    #1;
    compare_top();
  endtask

  initial begin
    mdl_reset();
    cycle("rst", 0, 0, 0, 0, 0);
    cycle("rst", 0, 0, 0, 0, 0);
    cycle("init", 1, 0, 0, 0, 0);
    repeat (3) cycle("idle", 1, 0, 0, 0, 0);

    cycle("lu_br", 1, 1, 1, 0, 0);
    cycle("br", 1, 0, 1, 0, 0);
    cycle("idle", 1, 0, 0, 0, 0);

    cycle("mreq", 1, 0, 0, 1, 0);
    cycle("mwait", 1, 1, 1, 1, 0);
    cycle("mwait", 1, 0, 1, 1, 0);
    cycle("mack", 1, 0, 0, 1, 1);
    cycle("idle", 1, 0, 0, 0, 0);

    cycle("mhit", 1, 0, 0, 1, 1);
    cycle("mhit_lu", 1, 1, 0, 1, 1);
    cycle("idle", 1, 0, 0, 0, 0);

    // Ack on the last wait cycle before the small instance would time out.
    cycle("awin_req", 1, 0, 0, 1, 0);
    repeat (3) cycle("awin_wait", 1, 0, 0, 1, 0);
    cycle("awin_ack", 1, 0, 1, 1, 1);
    cycle("awin_ack_lu", 1, 0, 0, 0, 0);
    cycle("mreq2", 1, 0, 0, 1, 0);
    cycle("mack_lu", 1, 1, 1, 1, 1);

    cycle("tmo_req", 1, 0, 0, 1, 0);
    repeat (70) cycle("tmo", 1, 0, 0, 1, 0);
    cycle("err_hold", 1, 1, 1, 0, 0);
    async_reset("arst_err");
    cycle("rst", 0, 0, 0, 0, 0);
    cycle("init", 1, 0, 0, 0, 0);

    cycle("arst_req", 1, 0, 0, 1, 0);
    cycle("arst_wait", 1, 0, 0, 1, 0);
    async_reset("arst_mw");
    cycle("init", 1, 0, 0, 0, 0);

    repeat (10) cycle("sat", 1, 1, 0, 0, 0);
    repeat (10) cycle("fsat", 1, 0, 1, 0, 0);

    for (int k = 0; k < 400; k++) begin
      cycle("rand", ($urandom_range(0, 60) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
